// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one EX-stage ALU between the pipeline EX slot (port 0)
// and the secondary address/debug unit (port 1). Each result lands in a per-port
// response buffer with valid/ready handshake, and per-port saturating grant
// counters give performance visibility.
// Optional macro ALU_ARB_RR_EN: round-robin arbitration on contention.
// Without it, port 0 always wins contention and no pointer register exists.
module alu_share_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              ctrl0_i,
  input  logic              ctrl1_i,
  input  logic [DATA_W-1:0] a0_i,
  input  logic [DATA_W-1:0] a1_i,
  input  logic [DATA_W-1:0] b0_i,
  input  logic [DATA_W-1:0] b1_i,
  input  logic [DATA_W-1:0] imm0_i,
  input  logic [DATA_W-1:0] imm1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [DATA_W-1:0] alu_imm_o,
  output logic              alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic              rsp0_valid_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp0_data_o,
  output logic [DATA_W-1:0] rsp1_data_o,
  input  logic              rsp0_ready_i,
  input  logic              rsp1_ready_i,
  output logic [CNT_W-1:0]  cnt0_o,
  output logic [CNT_W-1:0]  cnt1_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              elig0;
  logic              elig1;
  logic              gnt0;
  logic              gnt1;

  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q,  rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q,  rsp1_data_d;
  logic [CNT_W-1:0]  cnt0_q,       cnt0_d;
  logic [CNT_W-1:0]  cnt1_q,       cnt1_d;

  // A port may only win when its buffer is empty or is being drained this cycle;
  // grants are held off entirely while reset is asserted.
  assign elig0 = rst_n & req0_i & (~rsp0_valid_q | rsp0_ready_i);
  assign elig1 = rst_n & req1_i & (~rsp1_valid_q | rsp1_ready_i);

`ifdef ALU_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Round-robin pick on contention; pointer moves to the other port after a grant
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    ptr_d = ptr_q;
    if (elig0 && elig1) begin
      gnt0 = ~ptr_q;
      gnt1 = ptr_q;
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
    if (gnt0) begin
      ptr_d = 1'b1;
    end else if (gnt1) begin
      ptr_d = 1'b0;
    end
  end

  // Priority pointer register, starts favouring port 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the EX slot always wins contention
  always_comb begin
    gnt0 = elig0;
    gnt1 = elig1 & ~elig0;
  end
`endif

  // Steer the winner's payload to the ALU; idle ALU sees all zeros (ctrl=0 add)
  always_comb begin
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_imm_o  = '0;
    alu_ctrl_o = 1'b0;
    if (gnt0) begin
      alu_a_o    = a0_i;
      alu_b_o    = b0_i;
      alu_imm_o  = imm0_i;
      alu_ctrl_o = ctrl0_i;
    end else if (gnt1) begin
      alu_a_o    = a1_i;
      alu_b_o    = b1_i;
      alu_imm_o  = imm1_i;
      alu_ctrl_o = ctrl1_i;
    end
  end

  // Response buffers: a new grant overwrites (even while draining), a drain clears valid but keeps data
  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    if (gnt0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_result_i;
    end else if (rsp0_valid_q && rsp0_ready_i) begin
      rsp0_valid_d = 1'b0;
    end
    if (gnt1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_result_i;
    end else if (rsp1_valid_q && rsp1_ready_i) begin
      rsp1_valid_d = 1'b0;
    end
  end

  // Grant counters stick at all-ones rather than wrapping
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0 && (cnt0_q != CNT_MAX)) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
    if (gnt1 && (cnt1_q != CNT_MAX)) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any pending responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign gnt0_o       = gnt0;
  assign gnt1_o       = gnt1;
  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp0_data_o  = rsp0_data_q;
  assign rsp1_data_o  = rsp1_data_q;
  assign cnt0_o       = cnt0_q;
  assign cnt1_o       = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. A behavioural ALU closes the loop on alu_*;
// a second instance with CNT_W=2 exposes counter saturation. Expected responses
// are queued as grants are expected and popped by a monitor whenever a response
// is handed over (valid & ready).
module tb_alu_share_arbiter;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          req0, req1, ctrl0, ctrl1;
  logic [DW-1:0] a0, a1, b0, b1, imm0, imm1;
  logic          ready0, ready1;

  logic          gnt0, gnt1, aluCtrl;
  logic [DW-1:0] aluA, aluB, aluImm, aluResult;
  logic          rsp0Valid, rsp1Valid;
  logic [DW-1:0] rsp0Data, rsp1Data;
  logic [15:0]   cnt0, cnt1;

  logic          sGnt0, sGnt1, sAluCtrl;
  logic [DW-1:0] sAluA, sAluB, sAluImm, sAluResult;
  logic          sRsp0Valid, sRsp1Valid;
  logic [DW-1:0] sRsp0Data, sRsp1Data;
  logic [1:0]    sCnt0, sCnt1;

  int            passCount  = 0;
  int            checkCount = 0;
  int            expCnt0    = 0;
  int            expCnt1    = 0;
  int            expSat0    = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // Reference ALU: wrapping add, or left shift that yields 0 for amounts >= width
  function automatic logic [DW-1:0] aluModel(input logic c, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [DW-1:0] imm);
    if (!c) return a + b;
    if (imm >= DW) return '0;
    return a << imm;
  endfunction

  assign aluResult  = aluModel(aluCtrl, aluA, aluB, aluImm);
  assign sAluResult = aluModel(sAluCtrl, sAluA, sAluB, sAluImm);

  alu_share_arbiter #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0), .req1_i(req1), .ctrl0_i(ctrl0), .ctrl1_i(ctrl1),
    .a0_i(a0), .a1_i(a1), .b0_i(b0), .b1_i(b1), .imm0_i(imm0), .imm1_i(imm1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .alu_a_o(aluA), .alu_b_o(aluB), .alu_imm_o(aluImm), .alu_ctrl_o(aluCtrl),
    .alu_result_i(aluResult),
    .rsp0_valid_o(rsp0Valid), .rsp1_valid_o(rsp1Valid),
    .rsp0_data_o(rsp0Data), .rsp1_data_o(rsp1Data),
    .rsp0_ready_i(ready0), .rsp1_ready_i(ready1),
    .cnt0_o(cnt0), .cnt1_o(cnt1)
  );

  alu_share_arbiter #(.DATA_W(DW), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0), .req1_i(req1), .ctrl0_i(ctrl0), .ctrl1_i(ctrl1),
    .a0_i(a0), .a1_i(a1), .b0_i(b0), .b1_i(b1), .imm0_i(imm0), .imm1_i(imm1),
    .gnt0_o(sGnt0), .gnt1_o(sGnt1),
    .alu_a_o(sAluA), .alu_b_o(sAluB), .alu_imm_o(sAluImm), .alu_ctrl_o(sAluCtrl),
    .alu_result_i(sAluResult),
    .rsp0_valid_o(sRsp0Valid), .rsp1_valid_o(sRsp1Valid),
    .rsp0_data_o(sRsp0Data), .rsp1_data_o(sRsp1Data),
    .rsp0_ready_i(ready0), .rsp1_ready_i(ready1),
    .cnt0_o(sCnt0), .cnt1_o(sCnt1)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic r0, input logic c0, input logic [DW-1:0] ia0,
                               input logic [DW-1:0] ib0, input logic [DW-1:0] ii0,
                               input logic r1, input logic c1, input logic [DW-1:0] ia1,
                               input logic [DW-1:0] ib1, input logic [DW-1:0] ii1);
    req0 = r0; ctrl0 = c0; a0 = ia0; b0 = ib0; imm0 = ii0;
    req1 = r1; ctrl1 = c1; a1 = ia1; b1 = ib1; imm1 = ii1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the expected grants for the current inputs, queue the responses, advance one cycle
  task automatic cycleExpect(input logic eg0, input logic eg1);
    #1;
    checkOutput("gnt0", {31'd0, gnt0}, {31'd0, eg0});
    checkOutput("gnt1", {31'd0, gnt1}, {31'd0, eg1});
    if (eg0) begin
      q0.push_back(aluModel(ctrl0, a0, b0, imm0));
      expCnt0++;
      expSat0 = (expSat0 == 3) ? 3 : expSat0 + 1;
    end
    if (eg1) begin
      q1.push_back(aluModel(ctrl1, a1, b1, imm1));
      expCnt1++;
    end
    step();
  endtask

  // Assert reset mid-cycle, check cleared state, hold two cycles, release
  task automatic resetDuts();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    expCnt0 = 0; expCnt1 = 0; expSat0 = 0;
    #1;
    checkOutput("rst_rsp0_valid", {31'd0, rsp0Valid}, 32'd0);
    checkOutput("rst_rsp1_valid", {31'd0, rsp1Valid}, 32'd0);
    checkOutput("rst_cnt0", {16'd0, cnt0}, 32'd0);
    checkOutput("rst_cnt1", {16'd0, cnt1}, 32'd0);
    checkOutput("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    checkOutput("rst_alu", {aluA, aluB, aluImm, 7'd0, aluCtrl}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: every handed-over response must match the oldest expectation for that port
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0Valid && ready0) begin
        if (q0.size() == 0) checkOutput("rsp0_unexpected", {24'd0, rsp0Data}, 32'hFFFF_FFFF);
        else checkOutput("rsp0_data", {24'd0, rsp0Data}, {24'd0, q0.pop_front()});
      end
      if (rsp1Valid && ready1) begin
        if (q1.size() == 0) checkOutput("rsp1_unexpected", {24'd0, rsp1Data}, 32'hFFFF_FFFF);
        else checkOutput("rsp1_data", {24'd0, rsp1Data}, {24'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    ready0 = 1'b1;
    ready1 = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    checkOutput("init_valids", {30'd0, rsp0Valid, rsp1Valid}, 32'd0);
    checkOutput("init_data", {16'd0, rsp0Data, rsp1Data}, 32'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] test 1: reset with both buffers full");
    ready0 = 1'b0;
    ready1 = 1'b0;
    applyStimulus(1, 0, 8'h01, 8'h02, 0, 1, 0, 8'h03, 8'h04, 0);
    cycleExpect(1, 0);
    cycleExpect(0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_valids", {30'd0, rsp0Valid, rsp1Valid}, 32'd3);
    checkOutput("full_data", {16'd0, rsp0Data, rsp1Data}, 32'h0000_0307);
    req0 = 1'b1;
    resetDuts();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ready0 = 1'b1;
    ready1 = 1'b1;
    step();
    step();
    checkOutput("idle_valids", {30'd0, rsp0Valid, rsp1Valid}, 32'd0);
    checkOutput("idle_cnts", {cnt0, cnt1}, 32'd0);
    checkOutput("idle_alu", {aluA, aluB, aluImm, 7'd0, aluCtrl}, 32'd0);

    $display("[TB] test 2: single wrapping add on port 0");
    applyStimulus(1, 0, 8'hF0, 8'h20, 8'h00, 0, 0, 0, 0, 0);
    #1;
    checkOutput("add_alu_ab", {16'd0, aluA, aluB}, 32'h0000_F020);
    cycleExpect(1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("add_rsp0", {23'd0, rsp0Valid, rsp0Data}, 32'h0000_0110);
    checkOutput("add_cnt0", {16'd0, cnt0}, 32'd1);
    step();
    checkOutput("drain_hold", {23'd0, rsp0Valid, rsp0Data}, 32'h0000_0010);

    $display("[TB] test 3: shifts on port 1");
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 8'h03, 8'h55, 8'd2);
    cycleExpect(0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 8'h03, 8'h55, 8'd9);
    #1;
    checkOutput("shift_alu_ctrl_imm", {23'd0, aluCtrl, aluImm}, 32'h0000_0109);
    cycleExpect(0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("shift_cnt1", {16'd0, cnt1}, 32'd2);
    step();

    $display("[TB] test 4: sustained contention");
    applyStimulus(1, 0, 8'h01, 8'h01, 0, 1, 1, 8'h05, 8'h00, 8'd1);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      cycleExpect((i % 2) == 0, (i % 2) == 1);
`else
      cycleExpect(1, 0);
`endif
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ALU_ARB_RR_EN
    checkOutput("cont_cnts", {cnt0, cnt1}, {16'd3, 16'd4});
`else
    checkOutput("cont_cnts", {cnt0, cnt1}, {16'd5, 16'd2});
`endif
    checkOutput("model_cnts", {cnt0, cnt1}, {expCnt0[15:0], expCnt1[15:0]});
    step();

    $display("[TB] test 5: backpressure on port 0");
    ready0 = 1'b0;
    applyStimulus(1, 0, 8'h10, 8'h01, 0, 0, 0, 0, 0, 0);
    cycleExpect(1, 0);
    applyStimulus(1, 0, 8'h20, 8'h02, 0, 1, 1, 8'h01, 8'h00, 8'd3);
    cycleExpect(0, 1);
    applyStimulus(1, 0, 8'h20, 8'h02, 0, 0, 0, 0, 0, 0);
    cycleExpect(0, 0);
    checkOutput("bp_hold", {23'd0, rsp0Valid, rsp0Data}, 32'h0000_0111);
    ready0 = 1'b1;
    cycleExpect(1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bp_newdata", {23'd0, rsp0Valid, rsp0Data}, 32'h0000_0122);
    step();
    step();
    @(negedge clk);
    #1;
    checkOutput("queues_empty", q0.size() + q1.size(), 32'd0);

    $display("[TB] test 6: counter saturation at CNT_W=2");
    resetDuts();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, DW'(i), 8'h01, 0, 0, 0, 0, 0, 0);
      cycleExpect(1, 0);
      checkOutput("sat_cnt0", {30'd0, sCnt0}, expSat0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_final", {30'd0, sCnt0}, 32'd3);
    checkOutput("wide_final", {16'd0, cnt0}, 32'd5);
    checkOutput("sat_rsp0", {23'd0, sRsp0Valid, sRsp0Data}, 32'h0000_0105);
    step();
    @(negedge clk);
    #1;
    checkOutput("queues_empty_end", q0.size() + q1.size(), 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single EX-stage ALU between two requesters: port 0 is the pipeline EX slot and port 1 is the secondary unit (address/debug).
- Grants at most one ALU operation per cycle.
- Registers each result into a per-port response buffer with valid/ready backpressure.
- Keeps saturating per-port grant counters for performance visibility.

Parameters:
- DATA_W, 8: operand/result width; matches the ALU datapath.
- CNT_W, 16: width of each per-port grant counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_i / req1_i  in  1  operation request, held with a stable payload until granted.
- ctrl0_i / ctrl1_i  in  1  ALU op: 0 = A+B, 1 = A<<Imm.
- a0_i / a1_i  in  DATA_W  operand A (requester resolves forwarding before presenting).
- b0_i / b1_i  in  DATA_W  operand B.
- imm0_i / imm1_i  in  DATA_W  shift amount.
- gnt0_o / gnt1_o  out  1  combinational grant; request accepted this cycle.
- alu_a_o  out  DATA_W  to ALU A; ALU ForwardSignal is tied 0 by the integrator.
- alu_b_o  out  DATA_W  to ALU B.
- alu_imm_o  out  DATA_W  to ALU Imm.
- alu_ctrl_o  out  1  to ALU ctrl.
- alu_result_i  in  DATA_W  ALU combinational result.
- rsp0_valid_o / rsp1_valid_o  out  1  response buffer holds a result.
- rsp0_data_o / rsp1_data_o  out  DATA_W  buffered result.
- rsp0_ready_i / rsp1_ready_i  in  1  consumer takes the response this cycle.
- cnt0_o / cnt1_o  out  CNT_W  saturating grant count per port.

Behaviour:
- Reset (async assert, sync deassert in the system): all rsp*_valid_o=0, rsp*_data_o=0, cnt*_o=0, priority pointer=0. Grants are 0 while rst_n=0. Pending responses are dropped, with no replay.
- Eligibility: elig_k = req_k & (!rsp_k_valid | rsp_k_ready). A port with a full, undrained buffer is never granted.
- Grant: at most one of gnt0_o/gnt1_o high.
  - Only one port eligible: that port is granted.
  - Both eligible: priority per Optional Feature.
  - Neither eligible: no grant.
- ALU mux: alu_* driven from the granted port's payload. With no grant, all alu_* outputs are 0, which makes the ALU idle with ctrl=0.
- Latency: request granted in cycle N gives rsp_k_valid=1 and rsp_k_data=alu_result_i sampled at the N/N+1 edge, visible in cycle N+1.
- Response buffer per port, at the edge:
  - Grant to k: valid←1, data←result. Simultaneous drain plus new grant keeps valid=1 with new data (back-to-back throughput of 1/cycle per port).
  - Drain only (valid & ready, no grant): valid←0, data holds its last value.
  - Neither: hold.
- rsp_k_ready with valid=0 is ignored.
- Counters: cnt_k increments on each gnt_k and saturates at 2^CNT_W-1 with no wrap.
- Arithmetic is the ALU's: add wraps mod 2^DATA_W; shift amounts ≥ DATA_W yield 0. The arbiter never modifies data.
- A requester dropping req before grant is legal; nothing is recorded.

Optional Feature:
- Macro ALU_ARB_RR_EN.
- Defined: round-robin. A 1-bit pointer selects the winner on contention; after any grant to port k, pointer←other port. Pointer resets to 0.
- Undefined: fixed priority, port 0 always wins contention; no pointer register exists. Port 1 may starve under sustained port 0 traffic, which is accepted behaviour.

Test Plan:
1. Reset/idle: rst_n=0 mid-run with both buffers full → all valids 0, cnts 0, alu_* 0; after release with no req, outputs stay 0.
2. Single add: req0, ctrl0=0, a0=8'hF0, b0=8'h20 → gnt0_o=1 same cycle; next cycle rsp0_valid=1, rsp0_data=8'h10 (wrap); cnt0=1.
3. Shift on port 1: ctrl1=1, a1=8'h03, imm1=2 → rsp1_data=8'h0C; then imm1=9 → rsp1_data=8'h00.
4. Contention: req0 and req1 held high for 4 cycles, both ready=1.
   - RR build: grants alternate 0,1,0,1 and cnt0=cnt1=2.
   - Fixed build: gnt0 4 times, gnt1 0 times.
5. Backpressure: port 0 response held with ready0=0 and req0 asserted → gnt0_o stays 0 and port 1 is still served. Raise ready0 → same cycle gnt0_o=1, rsp0_valid stays 1 with new data.
6. Counter saturation (CNT_W=2): 5 grants to port 0 → cnt0 ends at 3.
